// File: rtl/sa_feed_skew.sv
`default_nettype none
// ============================================================================
// Module   : sa_feed_skew
// Purpose  : Input feeder for a registered systolic array. Accepts one A and
//            one B vector per handshake and re-times them into the diagonal
//            skew the array expects (lane i lags lane 0 by i cycles). After
//            the last vector of a tile it zero-flushes the skew pipeline and
//            pulses tile_done as the final element leaves lane HPE-1.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK        in   1          clock, rising edge
//   RST        in   1          synchronous active-high reset
//   a_in       in   WIDTH*HPE  A vector, lane i = a_in[i*WIDTH +: WIDTH]
//   b_in       in   WIDTH*HPE  B vector, same packing
//   in_valid   in   1          a_in/b_in/in_last valid
//   in_last    in   1          final vector of the tile
//   in_ready   out  1          feeder accepts a vector this cycle
//   sa_a       out  WIDTH*HPE  skewed A to the array
//   sa_b       out  WIDTH*HPE  skewed B to the array
//   lane_vld   out  HPE        lane i of sa_a/sa_b carries real data
//   tile_done  out  1          one-cycle pulse, tile fully drained
//   tile_cnt   out  CW         vectors accepted in current/most recent tile
//   ovf_err    out  1          sticky, a tile reached K_MAX without in_last
// ============================================================================
module sa_feed_skew #(
  parameter int HPE   = 4,
  parameter int WIDTH = 8,
  parameter int K_MAX = 256,
  parameter int CW    = 9
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH*HPE-1:0] a_in,
  input  logic [WIDTH*HPE-1:0] b_in,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WIDTH*HPE-1:0] sa_a,
  output logic [WIDTH*HPE-1:0] sa_b,
  output logic [HPE-1:0]       lane_vld,
  output logic                 tile_done,
  output logic [CW-1:0]        tile_cnt,
  output logic                 ovf_err
);

  // Flush counter must hold HPE-2.
  localparam int FW = (HPE > 2) ? $clog2(HPE - 1) : 1;
  localparam logic [FW-1:0] c_FLUSH_LOAD = FW'(HPE - 2);
  localparam logic [CW-1:0] c_CNT_LIMIT  = CW'(K_MAX - 1);
  localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [FW-1:0] r_fcnt,     w_fcnt_nxt;
  logic [CW-1:0] r_tile_cnt, w_tile_cnt_nxt;
  logic          r_ovf,      w_ovf_nxt;
  logic          r_done,     w_done_nxt;
  logic          w_acc;

  assign in_ready  = (r_state != S_FLUSH);
  assign w_acc     = in_valid & in_ready;
  assign tile_done = r_done;
  assign tile_cnt  = r_tile_cnt;
  assign ovf_err   = r_ovf;

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_fcnt     <= '0;
      r_tile_cnt <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_tile_cnt <= w_tile_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_fcnt_nxt     = r_fcnt;
    w_tile_cnt_nxt = r_tile_cnt;
    w_ovf_nxt      = r_ovf;
    w_done_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_tile_cnt_nxt = c_CNT_ONE;
          if (in_last) begin
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = c_FLUSH_LOAD;
          end else begin
            w_state_nxt = S_STREAM;
          end
        end
      end

      S_STREAM: begin
        if (w_acc) begin
          w_tile_cnt_nxt = r_tile_cnt + c_CNT_ONE;
          // Reaching K_MAX closes the tile even without in_last; that case
          // is recorded as a sticky overflow.
          if (in_last || (r_tile_cnt == c_CNT_LIMIT)) begin
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = c_FLUSH_LOAD;
          end
          if (!in_last && (r_tile_cnt == c_CNT_LIMIT)) begin
            w_ovf_nxt = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        // HPE-1 flush cycles: the edge leaving FLUSH is the one that moves
        // the last element onto lane HPE-1, so tile_done lines up with it.
        if (r_fcnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_fcnt_nxt = r_fcnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Skew pipeline: lane i is a chain of i+1 registers. Stage 0 loads zero with
  // valid low whenever nothing is accepted, so bubbles and flush slots reach
  // the array as MAC-neutral zeros.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < HPE; i++) begin : g_lane
      logic [WIDTH-1:0] r_pipe_a [0:i];
      logic [WIDTH-1:0] r_pipe_b [0:i];
      logic [i:0]       r_pipe_v;

      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int s = 0; s <= i; s++) begin
            r_pipe_a[s] <= '0;
            r_pipe_b[s] <= '0;
          end
          r_pipe_v <= '0;
        end else begin
          r_pipe_a[0] <= w_acc ? a_in[i*WIDTH +: WIDTH] : '0;
          r_pipe_b[0] <= w_acc ? b_in[i*WIDTH +: WIDTH] : '0;
          r_pipe_v[0] <= w_acc;
          for (int s = 1; s <= i; s++) begin
            r_pipe_a[s] <= r_pipe_a[s-1];
            r_pipe_b[s] <= r_pipe_b[s-1];
            r_pipe_v[s] <= r_pipe_v[s-1];
          end
        end
      end

      assign sa_a[i*WIDTH +: WIDTH] = r_pipe_a[i];
      assign sa_b[i*WIDTH +: WIDTH] = r_pipe_b[i];
      assign lane_vld[i]            = r_pipe_v[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sa_feed_skew.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_feed_skew
// Purpose  : Self-checking bench for sa_feed_skew (HPE=4, WIDTH=8, K_MAX=4).
//            Accepted vectors are pushed per lane with the edge on which they
//            must appear; tile ends push the edge on which tile_done must
//            pulse. Every cycle the lane outputs and tile_done are compared
//            against the queue heads (or zero when nothing is due).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_feed_skew;

  localparam int HPE   = 4;
  localparam int WIDTH = 8;
  localparam int K_MAX = 4;
  localparam int CW    = 9;
  localparam int DW    = HPE * WIDTH;

  logic           CLK = 1'b0;
  logic           RST;
  logic [DW-1:0]  a_in, b_in;
  logic           in_valid, in_last;
  logic           in_ready;
  logic [DW-1:0]  sa_a, sa_b;
  logic [HPE-1:0] lane_vld;
  logic           tile_done;
  logic [CW-1:0]  tile_cnt;
  logic           ovf_err;

  sa_feed_skew #(
    .HPE   (HPE),
    .WIDTH (WIDTH),
    .K_MAX (K_MAX),
    .CW    (CW)
  ) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sa_a      (sa_a),
    .sa_b      (sa_b),
    .lane_vld  (lane_vld),
    .tile_done (tile_done),
    .tile_cnt  (tile_cnt),
    .ovf_err   (ovf_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } lane_ent_t;

  lane_ent_t q_lane [HPE][$];
  int        q_done [$];
  int        edge_n   = 0;
  int        n_checks = 0;
  int        n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0]  ea, eb;
    logic [HPE-1:0] ev;
    logic           ed;
    lane_ent_t      e;
    ea = '0; eb = '0; ev = '0; ed = 1'b0;
    for (int i = 0; i < HPE; i++) begin
      if (q_lane[i].size() > 0) begin
        e = q_lane[i][0];
        if (e.due == edge_n) begin
          ea[i*WIDTH +: WIDTH] = e.a;
          eb[i*WIDTH +: WIDTH] = e.b;
          ev[i] = 1'b1;
          void'(q_lane[i].pop_front());
        end
      end
    end
    if (q_done.size() > 0) begin
      if (q_done[0] == edge_n) begin
        ed = 1'b1;
        void'(q_done.pop_front());
      end
    end
    check_eq("sa_a",      sa_a,      ea);
    check_eq("sa_b",      sa_b,      eb);
    check_eq("lane_vld",  lane_vld,  ev);
    check_eq("tile_done", tile_done, ed);
  endtask

  task automatic tick();
    @(posedge CLK);
    edge_n++;
    #1;
    check_outputs();
  endtask

  // Present one input cycle. rdy is the in_ready value the cycle must show;
  // ends marks an accept that closes the tile (in_last or K_MAX reached).
  task automatic drive(input logic v, input logic last, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic rdy, input logic ends);
    in_valid = v;
    in_last  = last;
    a_in     = a;
    b_in     = b;
    check_eq("in_ready", in_ready, rdy);
    if (v && rdy) begin
      for (int i = 0; i < HPE; i++) begin
        q_lane[i].push_back('{due: edge_n + 1 + i,
                              a:   a[i*WIDTH +: WIDTH],
                              b:   b[i*WIDTH +: WIDTH]});
      end
      if (ends) q_done.push_back(edge_n + HPE);
    end
    tick();
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) drive(1'b0, 1'b0, '0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    a_in     = '0;
    b_in     = '0;
    for (int i = 0; i < HPE; i++) q_lane[i].delete();
    q_done.delete();
    tick();
    RST = 1'b0;
    check_eq("rst_tile_cnt", tile_cnt, 0);
    check_eq("rst_ovf_err",  ovf_err,  0);
    check_eq("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int remaining;
    RST = 1'b1; in_valid = 1'b0; in_last = 1'b0; a_in = '0; b_in = '0;

    // 1: reset, then a 3-vector tile on consecutive cycles
    do_reset();
    drive(1, 0, 32'h04030201, 32'h84838281, 1, 0);
    drive(1, 0, 32'h14131211, 32'h94939291, 1, 0);
    drive(1, 1, 32'h24232221, 32'hA4A3A2A1, 1, 1);
    idle(3, 0);
    check_eq("t1_tile_cnt", tile_cnt, 3);
    idle(1, 1);

    // 2: two-cycle bubble mid-tile; in_last without in_valid is ignored
    drive(1, 0, 32'h34333231, 32'hB4B3B2B1, 1, 0);
    drive(1, 0, 32'h44434241, 32'hC4C3C2C1, 1, 0);
    drive(0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 1, 0);
    drive(0, 0, 32'h0, 32'h0, 1, 0);
    drive(1, 1, 32'h54535251, 32'hD4D3D2D1, 1, 1);
    idle(3, 0);
    check_eq("t2_tile_cnt", tile_cnt, 3);
    idle(1, 1);

    // 3: single-vector tile; vectors offered during FLUSH are refused
    drive(1, 1, 32'h64636261, 32'hE4E3E2E1, 1, 1);
    drive(1, 0, 32'h77777777, 32'h88888888, 0, 0);
    drive(1, 1, 32'h99999999, 32'hAAAAAAAA, 0, 0);
    drive(1, 0, 32'hBBBBBBBB, 32'hCCCCCCCC, 0, 0);
    check_eq("t3_tile_cnt", tile_cnt, 1);
    idle(1, 1);

    // 4: overflow at K_MAX=4, then a normal tile with ovf_err still set
    drive(1, 0, 32'h01020304, 32'h11121314, 1, 0);
    drive(1, 0, 32'h05060708, 32'h15161718, 1, 0);
    drive(1, 0, 32'h090A0B0C, 32'h191A1B1C, 1, 0);
    check_eq("t4_ovf_before", ovf_err, 0);
    check_eq("t4_cnt_before", tile_cnt, 3);
    drive(1, 0, 32'h0D0E0F10, 32'h1D1E1F20, 1, 1);
    idle(3, 0);
    check_eq("t4_ovf_set",   ovf_err,  1);
    check_eq("t4_tile_cnt",  tile_cnt, 4);
    drive(1, 0, 32'h21222324, 32'h31323334, 1, 0);
    drive(1, 1, 32'h25262728, 32'h35363738, 1, 1);
    idle(3, 0);
    check_eq("t4_ovf_sticky", ovf_err,  1);
    check_eq("t4_next_cnt",   tile_cnt, 2);
    idle(1, 1);

    // 6: back-to-back tiles, second tile starts in the tile_done cycle
    drive(1, 0, 32'h41424344, 32'h51525354, 1, 0);
    drive(1, 1, 32'h45464748, 32'h55565758, 1, 1);
    idle(3, 0);
    check_eq("t6_done_at_start", tile_done, 1);
    drive(1, 0, 32'h61626364, 32'h71727374, 1, 0);
    drive(1, 1, 32'h65666768, 32'h75767778, 1, 1);
    idle(3, 0);
    check_eq("t6_tile_cnt", tile_cnt, 2);
    idle(1, 1);

    // 5: reset mid-tile discards in-flight data and clears ovf_err
    drive(1, 0, 32'h81828384, 32'h91929394, 1, 0);
    drive(1, 0, 32'h85868788, 32'h95969798, 1, 0);
    do_reset();
    idle(6, 1);
    drive(1, 1, 32'hA1A2A3A4, 32'hB1B2B3B4, 1, 1);
    idle(3, 0);
    check_eq("t5_tile_cnt", tile_cnt, 1);
    idle(2, 1);

    remaining = q_done.size();
    for (int i = 0; i < HPE; i++) remaining += q_lane[i].size();
    check_eq("sb_drain", remaining, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sa_feed_skew.md
Name: sa_feed_skew

Overview:
- Input feeder placed directly upstream of the registered systolic-array top.
- Accepts one A vector and one B vector per handshake, each HPE lanes wide.
- Produces the diagonally skewed A/B streams the array needs: lane i is delayed i cycles more than lane 0.
- Enforces tile boundaries: after the last vector of a tile, it zero-flushes the skew pipeline, then pulses tile_done.

Parameters:
- HPE, 4: number of lanes (array rows/cols fed); must be >= 2.
- WIDTH, 8: operand width per lane.
- K_MAX, 256: maximum vectors per tile; overflow forces tile end.
- CW, 9: tile counter width; must satisfy 2^CW > K_MAX.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- a_in  in  WIDTH*HPE  A vector; lane i = a_in[i*WIDTH +: WIDTH].
- b_in  in  WIDTH*HPE  B vector; same lane packing.
- in_valid  in  1  a_in/b_in/in_last valid.
- in_last  in  1  marks final vector of the tile.
- in_ready  out  1  feeder can accept a vector this cycle.
- sa_a  out  WIDTH*HPE  skewed A to the array input.
- sa_b  out  WIDTH*HPE  skewed B to the array input.
- lane_vld  out  HPE  bit i = sa_a/sa_b lane i carries real data.
- tile_done  out  1  one-cycle pulse; last element has left lane HPE-1.
- tile_cnt  out  CW  vectors accepted in the current or most recent tile.
- ovf_err  out  1  sticky; a tile hit K_MAX without in_last.

Behaviour:
- Reset (RST=1 at an edge):
  - All skew registers, sa_a, sa_b and lane_vld cleared to 0.
  - tile_done=0, tile_cnt=0, ovf_err=0, state=IDLE.
  - Reset mid-tile discards all in-flight data; no tile_done is issued.
- Accept condition: acc = in_valid & in_ready. in_ready=1 in IDLE and STREAM, 0 in FLUSH.
- Skew pipeline: lane i is a chain of i+1 registers.
  - Stage 0 loads the lane operand when acc=1, else loads 0 with valid=0 (bubble).
  - Zeros are MAC-neutral, so bubbles never corrupt results.
  - Latency: data accepted at edge e appears on lane i during the cycle after edge e+i (lane 0: 1 cycle; lane HPE-1: HPE cycles).
  - lane_vld[i] travels with the data of lane i.
- FSM:
  - IDLE: acc & ~in_last -> STREAM, tile_cnt=1. acc & in_last -> FLUSH, tile_cnt=1.
  - STREAM: acc increments tile_cnt.
    - Go to FLUSH on acc & in_last.
    - Also go to FLUSH on acc when tile_cnt == K_MAX-1; the accepted vector is treated as last and ovf_err is set unless in_last=1.
    - No acc: stay in STREAM and inject bubbles.
  - FLUSH: lasts exactly HPE-1 cycles (flush counter loaded with HPE-2, decremented to 0). Zeros are injected. On the final FLUSH edge go to IDLE and register tile_done=1.
- tile_done timing: asserted during the same cycle that the last vector's element is on lane HPE-1 (HPE cycles after its accept edge). Low at all other times.
- tile_cnt holds its value in IDLE until the next tile's first accept, which overwrites it with 1.
- ovf_err clears only on RST.
- in_last is ignored when in_valid=0.
- Back-to-back tiles: a new tile is accepted in the IDLE cycle coincident with tile_done.

Test Plan:
1. HPE=4, WIDTH=8. After reset, check all outputs are 0 and in_ready=1. Send 3 vectors with a_in lanes {lane3..0} = {04,03,02,01},{14,13,12,11},{24,23,22,21} on consecutive cycles, in_last on the third.
   - Lane 0 shows 01,11,21 in cycles 1-3.
   - Lane 3 shows 04,14,24 in cycles 4-6.
   - tile_done=1 in cycle 6 only; tile_cnt=3.
2. Drop in_valid for 2 cycles mid-tile. Bubbles propagate diagonally with lane_vld low; sa_a=0 in those slots; ordering and tile_done timing shift by exactly 2.
3. Single-vector tile (in_last on the first accept).
   - in_ready=0 for 3 cycles.
   - tile_done arrives 4 cycles after the accept; tile_cnt=1.
   - A vector offered with in_valid=1 during FLUSH is not accepted.
4. K_MAX=4, no in_last. The 4th accept forces FLUSH, ovf_err=1 sticky, tile_cnt=4. The next tile starts normally with ovf_err still 1.
5. Assert RST for 1 cycle while lanes hold data in STREAM.
   - The following cycle: all outputs are 0, state is IDLE, in_ready=1.
   - No tile_done occurs.
6. Two tiles back-to-back, with the second tile's first vector offered in the tile_done cycle. It is accepted, and the lane HPE-1 outputs of the two tiles are separated by exactly 3 zero slots.
